// File: rtl/booth_pkg.sv
// Shared definitions for the Booth partial-product accumulator.
// Holds the default datapath parameters, the accumulator state encoding,
// and a helper that sizes the partial-product index counter.
package booth_pkg;

  localparam int DEFAULT_P_W   = 64;
  localparam int DEFAULT_SHIFT = 4;
  localparam int DEFAULT_NPP   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } acc_state_e;

  // Index counter width: ceil(log2(n)), but never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pp_align.sv
// Combinational alignment of one partial product.
// Ports:
//   data_i : partial product as delivered by the Booth encoder
//   k_i    : index of this partial product within the operation
//   data_o : data_i << (k_i*SHIFT), truncated to P_W bits
module pp_align
  import booth_pkg::*;
#(
  parameter int P_W   = DEFAULT_P_W,
  parameter int SHIFT = DEFAULT_SHIFT,
  parameter int KW    = 3
) (
  input  logic [P_W-1:0] data_i,
  input  logic [KW-1:0]  k_i,
  output logic [P_W-1:0] data_o
);

  logic [31:0] sh_amt;

  // Shift amounts of P_W or more simply yield zero, which is the
  // required modulo-2^P_W behaviour.
  assign sh_amt = 32'(k_i) * 32'(SHIFT);
  assign data_o = data_i << sh_amt;

endmodule

// File: rtl/pp_seq_accumulator.sv
// Sequential accumulator for Booth partial products.
// Partial product k (from 0) is added as pp_data << (k*SHIFT), modulo
// 2^P_W. An operation ends on pp_last, or is truncated after NPP
// products with res_err set. The result is held until res_ready.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous abort, overrides everything
//   pp_valid/pp_ready   : partial-product handshake
//   pp_data, pp_last    : partial product and end-of-operation marker
//   res_valid/res_ready : result handshake
//   res_data, res_err   : accumulated value and truncation flag
module pp_seq_accumulator
  import booth_pkg::*;
#(
  parameter int P_W   = DEFAULT_P_W,
  parameter int SHIFT = DEFAULT_SHIFT,
  parameter int NPP   = DEFAULT_NPP
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           pp_valid,
  output logic           pp_ready,
  input  logic [P_W-1:0] pp_data,
  input  logic           pp_last,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [P_W-1:0] res_data,
  output logic           res_err
);

  localparam int KW = idx_w(NPP);

  acc_state_e     state_q, state_d;
  logic [P_W-1:0] acc_q, acc_d;
  logic [KW-1:0]  k_q, k_d;
  logic           err_q, err_d;

  logic [P_W-1:0] aligned;
  logic           accept;

  pp_align #(
    .P_W  (P_W),
    .SHIFT(SHIFT),
    .KW   (KW)
  ) u_align (
    .data_i(pp_data),
    .k_i   (k_q),
    .data_o(aligned)
  );

  assign accept = pp_valid && pp_ready;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    k_d     = k_q;
    err_d   = err_q;
    if (flush) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      k_d     = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            // First product replaces whatever the previous result left.
            acc_d = pp_data;
            k_d   = KW'(1);
            if (pp_last || (NPP == 1)) begin
              state_d = ST_DONE;
              err_d   = (NPP == 1) && !pp_last;
            end else begin
              state_d = ST_ACC;
            end
          end
        end
        ST_ACC: begin
          if (accept) begin
            acc_d = acc_q + aligned;
            k_d   = k_q + KW'(1);
            if (pp_last) begin
              state_d = ST_DONE;
            end else if (k_q == KW'(NPP - 1)) begin
              state_d = ST_DONE;
              err_d   = 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            state_d = ST_IDLE;
            k_d     = '0;
            err_d   = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    pp_ready  = ((state_q == ST_IDLE) || (state_q == ST_ACC)) && !flush;
    res_valid = (state_q == ST_DONE);
    res_data  = acc_q;
    res_err   = err_q;
  end

endmodule
